monitor_prg_in_cond: RTL
========================

MONITOR_PRG_IN_COND -- requirements
Module: monitor_prg_in_cond

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: number of input bits conditioned.
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 50000: consecutive cycles a changed input must persist before acceptance; legal range 1..2^20.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port raw_in  input  WIDTH: asynchronous switch/key levels from board pins.
REQ-006 SHALL have port clr_flags  input  WIDTH: per-bit clear of sticky event flags, sampled on clk.
REQ-007 SHALL have port in_port  output  WIDTH: debounced levels; drives the 8-bit in_port of the downstream PIO read slave.
REQ-008 SHALL have port rise_pulse  output  WIDTH: one-cycle pulse per bit on an accepted 0->1 transition.
REQ-009 SHALL have port fall_pulse  output  WIDTH: one-cycle pulse per bit on an accepted 1->0 transition.
REQ-010 SHALL have port event_flags  output  WIDTH: sticky per-bit flag, set by any accepted transition.

Function
REQ-011 SHALL pass raw_in through a two-flop synchronizer (sync1, sync2) per bit; no logic between the flops.
REQ-012 SHALL keep, per bit, an independent counter of width ceil(log2(DEBOUNCE_CYCLES))+1 and a stable register driving in_port.
REQ-013 Per bit, each cycle: sync2 == stable -> counter cleared to 0, stable held.
REQ-014 Per bit, each cycle: sync2 != stable and counter < DEBOUNCE_CYCLES-1 -> counter increments by 1.
REQ-015 Per bit, each cycle: sync2 != stable and counter == DEBOUNCE_CYCLES-1 -> stable <= sync2, counter <= 0 (acceptance).
REQ-016 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change in_port; any return to the stable level restarts the count from 0.
REQ-017 Latency: raw_in change held steady before rising edge k SHALL appear on in_port after edge k+1+DEBOUNCE_CYCLES.
REQ-018 DEBOUNCE_CYCLES == 1 SHALL accept a change on the first differing synchronized cycle; counter never exceeds 0.
REQ-019 Counter SHALL never wrap; its maximum value is DEBOUNCE_CYCLES-1.
REQ-020 rise_pulse[i] SHALL be 1 for exactly the one cycle following acceptance of stable[i] 0->1; fall_pulse[i] likewise for 1->0; both registered, never simultaneously 1.
REQ-021 event_flags[i] SHALL be set the same cycle rise_pulse[i] or fall_pulse[i] is 1, held until cleared.
REQ-022 clr_flags[i]==1 SHALL clear event_flags[i] on the next edge; if a set and clr_flags[i] coincide, set SHALL win (flag = 1).
REQ-023 All bits SHALL operate independently; simultaneous transitions on multiple bits SHALL each be accepted on their own schedule.
REQ-024 All outputs SHALL be registered; no combinational path from raw_in or clr_flags to any output.

Reset
REQ-025 reset==1 at a rising edge SHALL set sync1, sync2, stable, counters, in_port, rise_pulse, fall_pulse, event_flags to 0.
REQ-026 Reset asserted mid-count SHALL discard the count; after release, counting restarts from 0 against stable=0.
REQ-027 reset SHALL take priority over every other update, including acceptance and flag set.
REQ-028 After release, a raw_in bit held at 1 SHALL be accepted as a normal 0->1 transition (rise_pulse and flag fire).

Verification (DEBOUNCE_CYCLES=4, WIDTH=8)
REQ-029 Reset, then raw_in 0x00->0x01 before edge 10, held -> in_port=0x01 after edge 15; rise_pulse=0x01 for one cycle after edge 16; event_flags=0x01 thereafter.
REQ-030 raw_in[0] pulse high for 3 cycles, then low -> in_port, rise_pulse, event_flags remain 0x00.
REQ-031 raw_in 0x00->0xA5 held -> in_port=0xA5 after 6 edges; rise_pulse=0xA5 for one cycle; then raw_in->0x00 held -> fall_pulse=0xA5 one cycle, event_flags=0xA5.
REQ-032 event_flags=0x01, assert clr_flags=0x01 on the same edge a new accepted transition sets bit 0 -> event_flags stays 0x01; clr_flags=0x01 alone next cycle -> 0x00.
REQ-033 raw_in=0xFF held, assert reset for 1 cycle while counters are at 2 -> all outputs 0x00; after release in_port=0xFF 6 edges later, rise_pulse=0xFF once.
REQ-034 DEBOUNCE_CYCLES=1 rebuild: raw_in 0x00->0x80 before edge k -> in_port=0x80 after edge k+2.

Source files
------------

// File: rtl/monitor_prg_in_cond.sv
// monitor_prg_in_cond
// Conditions a bank of asynchronous switch/key inputs for a PIO read slave.
// Each bit is synchronized, then debounced. A changed level is accepted only
// after it has persisted for DEBOUNCE_CYCLES consecutive synchronized cycles.
// Accepted transitions produce one-cycle edge pulses and set a sticky flag.
//
// Ports:
//   clk          - single clock, all state updates on the rising edge
//   reset        - synchronous, active-high reset
//   raw_in       - raw switch/key levels straight from the board pins
//   clr_flags    - per-bit clear of event_flags, sampled on clk
//   in_port      - debounced levels, feeds the PIO in_port
//   rise_pulse   - one-cycle pulse per bit after an accepted 0->1 change
//   fall_pulse   - one-cycle pulse per bit after an accepted 1->0 change
//   event_flags  - sticky per-bit flag, set by any accepted change
module monitor_prg_in_cond #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] clr_flags,
  output logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] event_flags
);

  // One spare bit above what DEBOUNCE_CYCLES-1 needs keeps the width legal
  // when DEBOUNCE_CYCLES is 1 (the counter then never leaves 0).
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] rise_set;
  logic [WIDTH-1:0] fall_set;

  // Two-flop synchronizer; nothing may sit between the flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce. Any cycle where the synchronized level agrees with the
  // accepted level restarts the count, so short glitches never get through.
  // The count saturates at CNT_MAX because reaching it triggers acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Edge detection compares the accepted level with its one-cycle-old copy;
  // the pulses are registered, so they appear the cycle after acceptance.
  assign rise_set = stable & ~stable_d;
  assign fall_set = ~stable & stable_d;

  // Pulse and flag registers. A set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d    <= '0;
      rise_pulse  <= '0;
      fall_pulse  <= '0;
      event_flags <= '0;
    end else begin
      stable_d    <= stable;
      rise_pulse  <= rise_set;
      fall_pulse  <= fall_set;
      event_flags <= (event_flags & ~clr_flags) | rise_set | fall_set;
    end
  end

  assign in_port = stable;

endmodule
